// File: rtl/jtag_pkg.sv
// Shared JTAG definitions for the boundary-scan wrapper: instruction codes
// and the decoded instruction type.
package jtag_pkg;

    typedef logic [1:0] instr_t;

    localparam instr_t EXTEST         = 2'b00;
    localparam instr_t SAMPLE_PRELOAD = 2'b01;
    localparam instr_t INTEST         = 2'b10;
    localparam instr_t BYPASS         = 2'b11;

    function automatic logic is_bypass(instr_t instr);
        return instr == BYPASS;
    endfunction

endpackage

// File: rtl/boundary_scan_register_cell.sv
// One boundary-scan cell: capture/shift flop, update flop and the
// functional-path mux that selects between the pin and the update flop.
module boundary_scan_cell_sync (
    input  logic clk,
    input  logic rst,
    input  logic capture_data,
    input  logic serial_in,
    output logic serial_out,
    input  logic capture_en,
    input  logic shift_en,
    input  logic update_en,
    input  logic mode_sel,
    input  logic func_in,
    output logic func_out
);

    logic shift_q;
    logic shift_d;
    logic update_q;
    logic update_d;

    // Capture outranks shift; update always samples the pre-edge shift value.
    always_comb begin
        shift_d  = shift_q;
        update_d = update_q;
        if (capture_en) begin
            shift_d = capture_data;
        end else if (shift_en) begin
            shift_d = serial_in;
        end
        if (update_en) begin
            update_d = shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q  <= 1'b0;
            update_q <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            update_q <= update_d;
        end
    end

    assign serial_out = shift_q;
    assign func_out   = mode_sel ? update_q : func_in;

endmodule

// File: rtl/boundary_scan_register.sv
// Boundary-scan data register wrapping both sides of a core: input cells,
// then output cells, in one TDI-to-TDO chain, plus the bypass register.
module boundary_scan_register
    import jtag_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int N_OUT = 17
) (
    input  logic               TCK,
    input  logic               RST,
    input  logic [1:0]         Instr,
    input  logic               CaptureDR,
    input  logic               ShiftDR,
    input  logic               UpdateDR,
    input  logic               TDI,
    output logic               TDO,
    input  logic [N_IN-1:0]    pin_in,
    output logic [N_IN-1:0]    core_in,
    input  logic [N_OUT-1:0]   core_out,
    output logic [N_OUT-1:0]   pin_out
);

    localparam int L = N_IN + N_OUT;

    instr_t instr;
    logic   in_bypass;
    logic   sel_intest;
    logic   sel_extest;
    logic   cell_capture;
    logic   cell_shift;
    logic   cell_update;
    logic   bypass_q;
    logic   bypass_d;
    logic [L:0] chain;

    assign instr = instr_t'(Instr);

    // BYPASS freezes every boundary cell so its contents survive the interval.
    always_comb begin
        in_bypass    = is_bypass(instr);
        sel_intest   = (instr == INTEST);
        sel_extest   = (instr == EXTEST);
        cell_capture = CaptureDR & ~in_bypass;
        cell_shift   = ShiftDR   & ~in_bypass;
        cell_update  = UpdateDR  & ~in_bypass;
    end

    assign chain[0] = TDI;

    for (genvar i = 0; i < N_IN; i++) begin : g_in_cell
        boundary_scan_cell_sync u_cell (
            .clk          (TCK),
            .rst          (RST),
            .capture_data (pin_in[i]),
            .serial_in    (chain[i]),
            .serial_out   (chain[i+1]),
            .capture_en   (cell_capture),
            .shift_en     (cell_shift),
            .update_en    (cell_update),
            .mode_sel     (sel_intest),
            .func_in      (pin_in[i]),
            .func_out     (core_in[i])
        );
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_out_cell
        boundary_scan_cell_sync u_cell (
            .clk          (TCK),
            .rst          (RST),
            .capture_data (core_out[j]),
            .serial_in    (chain[N_IN+j]),
            .serial_out   (chain[N_IN+j+1]),
            .capture_en   (cell_capture),
            .shift_en     (cell_shift),
            .update_en    (cell_update),
            .mode_sel     (sel_extest),
            .func_in      (core_out[j]),
            .func_out     (pin_out[j])
        );
    end

    always_comb begin
        bypass_d = bypass_q;
        if (in_bypass) begin
            if (CaptureDR) begin
                bypass_d = 1'b0;
            end else if (ShiftDR) begin
                bypass_d = TDI;
            end
        end
    end

    always_ff @(posedge TCK) begin
        if (RST) begin
            bypass_q <= 1'b0;
        end else begin
            bypass_q <= bypass_d;
        end
    end

    // Plain combinational select; falling-edge retiming is done by the TAP.
    assign TDO = in_bypass ? bypass_q : chain[L];

endmodule

// File: tb/tb_boundary_scan_register.sv
// Bench for boundary_scan_register (4 input cells, 3 output cells): a directed
// vector table, a serial-latency sequence and random traffic against a model.
module tb_boundary_scan_register;
    import jtag_pkg::*;

    localparam int N_IN  = 4;
    localparam int N_OUT = 3;
    localparam int L     = N_IN + N_OUT;

    logic             TCK = 1'b0;
    logic             RST = 1'b0;
    logic [1:0]       Instr = SAMPLE_PRELOAD;
    logic             CaptureDR = 1'b0;
    logic             ShiftDR = 1'b0;
    logic             UpdateDR = 1'b0;
    logic             TDI = 1'b0;
    logic             TDO;
    logic [N_IN-1:0]  pin_in = '0;
    logic [N_IN-1:0]  core_in;
    logic [N_OUT-1:0] core_out = '0;
    logic [N_OUT-1:0] pin_out;

    int checks = 0;
    int errors = 0;

    // Reference model: whole chain as one vector, bit k is cell k from TDI.
    logic [L-1:0] m_shift = '0;
    logic [L-1:0] m_update = '0;
    logic         m_bypass = 1'b0;

    boundary_scan_register #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .TCK       (TCK),
        .RST       (RST),
        .Instr     (Instr),
        .CaptureDR (CaptureDR),
        .ShiftDR   (ShiftDR),
        .UpdateDR  (UpdateDR),
        .TDI       (TDI),
        .TDO       (TDO),
        .pin_in    (pin_in),
        .core_in   (core_in),
        .core_out  (core_out),
        .pin_out   (pin_out)
    );

    always #5 TCK = ~TCK;

    typedef struct packed {
        logic       rst;
        logic [1:0] instr;
        logic       cap;
        logic       sh;
        logic       upd;
        logic       tdi;
        logic [3:0] pin;
        logic [2:0] cout;
        logic       exp_tdo;
        logic [3:0] exp_ci;
        logic [2:0] exp_po;
    } vec_t;

    vec_t vecs[33];

    function automatic vec_t mk(logic rst, logic [1:0] instr, logic cap, logic sh, logic upd,
                                logic tdi, logic [3:0] pin, logic [2:0] cout,
                                logic etdo, logic [3:0] eci, logic [2:0] epo);
        vec_t v;
        v.rst = rst; v.instr = instr; v.cap = cap; v.sh = sh; v.upd = upd; v.tdi = tdi;
        v.pin = pin; v.cout = cout; v.exp_tdo = etdo; v.exp_ci = eci; v.exp_po = epo;
        return v;
    endfunction

    // Drive one cycle of inputs, clock it, and advance the model from the spec rules.
    task automatic applyStimulus(input logic rst, input logic [1:0] instr, input logic cap,
                                 input logic sh, input logic upd, input logic tdi,
                                 input logic [3:0] pin, input logic [2:0] cout);
        @(negedge TCK);
        RST = rst; Instr = instr; CaptureDR = cap; ShiftDR = sh; UpdateDR = upd;
        TDI = tdi; pin_in = pin; core_out = cout;
        @(posedge TCK);
        if (rst) begin
            m_shift = '0; m_update = '0; m_bypass = 1'b0;
        end else if (instr == BYPASS) begin
            if (cap) m_bypass = 1'b0;
            else if (sh) m_bypass = tdi;
        end else begin
            if (upd) m_update = m_shift;
            if (cap) m_shift = {cout, pin};
            else if (sh) m_shift = {m_shift[L-2:0], tdi};
        end
        #1;
    endtask

    task automatic checkOutput(input string name, input logic etdo,
                               input logic [3:0] eci, input logic [2:0] epo);
        checks++;
        if (TDO !== etdo) begin
            errors++;
            $display("[TB] FAIL %s TDO got %b expected %b", name, TDO, etdo);
        end
        checks++;
        if (core_in !== eci) begin
            errors++;
            $display("[TB] FAIL %s core_in got %b expected %b", name, core_in, eci);
        end
        checks++;
        if (pin_out !== epo) begin
            errors++;
            $display("[TB] FAIL %s pin_out got %b expected %b", name, pin_out, epo);
        end
    endtask

    function automatic logic model_tdo();
        return (Instr == BYPASS) ? m_bypass : m_shift[L-1];
    endfunction

    function automatic logic [3:0] model_core_in();
        return (Instr == INTEST) ? m_update[N_IN-1:0] : pin_in;
    endfunction

    function automatic logic [2:0] model_pin_out();
        return (Instr == EXTEST) ? m_update[L-1:N_IN] : core_out;
    endfunction

    initial begin
        // Reset with shift active; capture/shift a preload pattern; update.
        vecs[0]  = mk(1, SAMPLE_PRELOAD, 0, 1, 0, 1, 4'b1010, 3'b011, 0, 4'b1010, 3'b011);
        vecs[1]  = mk(1, SAMPLE_PRELOAD, 0, 1, 0, 1, 4'b1010, 3'b011, 0, 4'b1010, 3'b011);
        vecs[2]  = mk(0, SAMPLE_PRELOAD, 1, 0, 0, 0, 4'b1010, 3'b011, 0, 4'b1010, 3'b011);
        vecs[3]  = mk(0, SAMPLE_PRELOAD, 0, 1, 0, 1, 4'b1010, 3'b011, 1, 4'b1010, 3'b011);
        vecs[4]  = mk(0, SAMPLE_PRELOAD, 0, 1, 0, 1, 4'b1010, 3'b011, 1, 4'b1010, 3'b011);
        vecs[5]  = mk(0, SAMPLE_PRELOAD, 0, 1, 0, 0, 4'b1010, 3'b011, 1, 4'b1010, 3'b011);
        vecs[6]  = mk(0, SAMPLE_PRELOAD, 0, 1, 0, 0, 4'b1010, 3'b011, 0, 4'b1010, 3'b011);
        vecs[7]  = mk(0, SAMPLE_PRELOAD, 0, 1, 0, 1, 4'b1010, 3'b011, 1, 4'b1010, 3'b011);
        vecs[8]  = mk(0, SAMPLE_PRELOAD, 0, 1, 0, 0, 4'b1010, 3'b011, 0, 4'b1010, 3'b011);
        vecs[9]  = mk(0, SAMPLE_PRELOAD, 0, 1, 0, 1, 4'b1010, 3'b011, 1, 4'b1010, 3'b011);
        vecs[10] = mk(0, SAMPLE_PRELOAD, 0, 0, 1, 0, 4'b1010, 3'b011, 1, 4'b1010, 3'b011);
        // EXTEST drives the preloaded 110, INTEST drives 0101, then INTEST capture.
        vecs[11] = mk(0, EXTEST,         0, 0, 0, 0, 4'b1010, 3'b011, 1, 4'b1010, 3'b110);
        vecs[12] = mk(0, EXTEST,         0, 0, 0, 0, 4'b1010, 3'b100, 1, 4'b1010, 3'b110);
        vecs[13] = mk(0, INTEST,         0, 0, 0, 0, 4'b0110, 3'b100, 1, 4'b0101, 3'b100);
        vecs[14] = mk(0, INTEST,         0, 0, 0, 0, 4'b1001, 3'b100, 1, 4'b0101, 3'b100);
        vecs[15] = mk(0, INTEST,         1, 0, 0, 0, 4'b1001, 3'b101, 1, 4'b0101, 3'b101);
        vecs[16] = mk(0, INTEST,         0, 1, 0, 0, 4'b1001, 3'b101, 0, 4'b0101, 3'b101);
        vecs[17] = mk(0, INTEST,         0, 1, 0, 0, 4'b1001, 3'b101, 1, 4'b0101, 3'b101);
        // Capture beats shift; shift+update latches the pre-shift values.
        vecs[18] = mk(0, SAMPLE_PRELOAD, 1, 1, 0, 1, 4'b1111, 3'b000, 0, 4'b1111, 3'b000);
        vecs[19] = mk(0, SAMPLE_PRELOAD, 0, 1, 1, 0, 4'b1111, 3'b000, 0, 4'b1111, 3'b000);
        vecs[20] = mk(0, EXTEST,         0, 0, 0, 0, 4'b1111, 3'b111, 0, 4'b1111, 3'b000);
        vecs[21] = mk(0, INTEST,         0, 0, 0, 0, 4'b0000, 3'b111, 0, 4'b1111, 3'b111);
        // BYPASS: one-bit path, boundary cells frozen even with UpdateDR.
        vecs[22] = mk(0, BYPASS,         1, 0, 0, 0, 4'b0000, 3'b111, 0, 4'b0000, 3'b111);
        vecs[23] = mk(0, BYPASS,         0, 1, 0, 1, 4'b0000, 3'b111, 1, 4'b0000, 3'b111);
        vecs[24] = mk(0, BYPASS,         0, 1, 0, 0, 4'b0000, 3'b111, 0, 4'b0000, 3'b111);
        vecs[25] = mk(0, BYPASS,         0, 1, 1, 1, 4'b0000, 3'b111, 1, 4'b0000, 3'b111);
        vecs[26] = mk(0, SAMPLE_PRELOAD, 0, 0, 0, 0, 4'b0000, 3'b111, 0, 4'b0000, 3'b111);
        vecs[27] = mk(0, SAMPLE_PRELOAD, 0, 1, 0, 0, 4'b0000, 3'b111, 0, 4'b0000, 3'b111);
        vecs[28] = mk(0, SAMPLE_PRELOAD, 0, 1, 0, 0, 4'b0000, 3'b111, 1, 4'b0000, 3'b111);
        vecs[29] = mk(0, INTEST,         0, 0, 0, 0, 4'b0000, 3'b111, 1, 4'b1111, 3'b111);
        // Reset during a shift clears everything, including update flops.
        vecs[30] = mk(1, SAMPLE_PRELOAD, 0, 1, 1, 1, 4'b0000, 3'b111, 0, 4'b0000, 3'b111);
        vecs[31] = mk(0, INTEST,         0, 0, 0, 0, 4'b0000, 3'b111, 0, 4'b0000, 3'b111);
        vecs[32] = mk(0, EXTEST,         0, 0, 0, 0, 4'b0110, 3'b111, 0, 4'b0110, 3'b000);

        for (int i = 0; i < 33; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].instr, vecs[i].cap, vecs[i].sh, vecs[i].upd,
                          vecs[i].tdi, vecs[i].pin, vecs[i].cout);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_tdo, vecs[i].exp_ci, vecs[i].exp_po);
        end

        // Serial latency: a lone 1 shifted into a cleared chain reaches TDO after L shifts.
        begin
            int seen_at;
            seen_at = -1;
            applyStimulus(1, SAMPLE_PRELOAD, 0, 0, 0, 0, 4'b0000, 3'b000);
            for (int n = 1; n <= 2 * L; n++) begin
                applyStimulus(0, SAMPLE_PRELOAD, 0, 1, 0, (n == 1), 4'b0000, 3'b000);
                if (TDO === 1'b1) begin
                    seen_at = n;
                    break;
                end
            end
            checks++;
            if (seen_at != L) begin
                errors++;
                $display("[TB] FAIL latency shifts got %0d expected %0d", seen_at, L);
            end
        end

        // Random traffic against the model.
        applyStimulus(1, SAMPLE_PRELOAD, 0, 0, 0, 0, 4'b0000, 3'b000);
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          2'($urandom_range(0, 3)),
                          ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 1) == 0),
                          ($urandom_range(0, 4) == 0),
                          1'($urandom),
                          4'($urandom),
                          3'($urandom));
            checkOutput($sformatf("rand%0d", i), model_tdo(), model_core_in(), model_pin_out());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
